// File: rtl/sr_cmd_conditioner.sv
// rtl/sr_cmd_conditioner.sv - SR flip-flop command conditioner: sync, debounce, edge detect, arbitrate, pulse with hold-off
// Optional conflict counter enabled by defining SRCMD_CONFLICT_CNT_EN.
module sr_cmd_conditioner #(
  parameter int DB_CYCLES    = 4,
  parameter int DB_W         = 3,
  parameter int HOLD_CYCLES  = 2,
  parameter int HOLD_W       = 2,
  parameter int PRIORITY_SET = 1,
  parameter int CONF_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_in,
  input  logic              clr_in,
  output logic              s,
  output logic              r,
  output logic              busy
`ifdef SRCMD_CONFLICT_CNT_EN
  ,
  output logic [CONF_W-1:0] conflict_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t            state;
  logic [1:0]        set_sync, clr_sync;
  logic [DB_W-1:0]   set_cnt, clr_cnt;
  logic              set_db, clr_db;
  logic              set_prev, clr_prev;
  logic              set_pend, clr_pend;
  logic [HOLD_W-1:0] hold_cnt;

  logic set_rise, clr_rise, set_req, clr_req;

  // A fresh rising edge is treated as a request in the same cycle it is seen,
  // so the pending flag does not add a cycle of latency when the FSM is idle.
  assign set_rise = set_db & ~set_prev;
  assign clr_rise = clr_db & ~clr_prev;
  assign set_req  = set_pend | set_rise;
  assign clr_req  = clr_pend | clr_rise;

  // Two-flop synchronisers for the raw asynchronous request levels
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      set_sync <= 2'b00;
      clr_sync <= 2'b00;
    end else begin
      set_sync <= {set_sync[0], set_in};
      clr_sync <= {clr_sync[0], clr_in};
    end
  end

  // Debounce: accept a new level only after DB_CYCLES consecutive disagreeing cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      set_cnt <= '0;
      set_db  <= 1'b0;
      clr_cnt <= '0;
      clr_db  <= 1'b0;
    end else begin
      if (set_sync[1] == set_db) begin
        set_cnt <= '0;
      end else if (set_cnt == DB_W'(DB_CYCLES - 1)) begin
        set_db  <= set_sync[1];
        set_cnt <= '0;
      end else begin
        set_cnt <= set_cnt + DB_W'(1);
      end

      if (clr_sync[1] == clr_db) begin
        clr_cnt <= '0;
      end else if (clr_cnt == DB_W'(DB_CYCLES - 1)) begin
        clr_db  <= clr_sync[1];
        clr_cnt <= '0;
      end else begin
        clr_cnt <= clr_cnt + DB_W'(1);
      end
    end
  end

  // Edge history of the debounced levels
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      set_prev <= 1'b0;
      clr_prev <= 1'b0;
    end else begin
      set_prev <= set_db;
      clr_prev <= clr_db;
    end
  end

  // Arbitration FSM with registered pulse outputs and hold-off gap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      s        <= 1'b0;
      r        <= 1'b0;
      busy     <= 1'b0;
      set_pend <= 1'b0;
      clr_pend <= 1'b0;
      hold_cnt <= '0;
    end else begin
      s        <= 1'b0;
      r        <= 1'b0;
      set_pend <= set_req;
      clr_pend <= clr_req;
      case (state)
        IDLE: begin
          if (set_req && clr_req) begin
            // Loser of a simultaneous request is dropped, not deferred
            if (PRIORITY_SET != 0) s <= 1'b1;
            else                   r <= 1'b1;
            set_pend <= 1'b0;
            clr_pend <= 1'b0;
            busy     <= 1'b1;
            state    <= PULSE;
          end else if (set_req) begin
            s        <= 1'b1;
            set_pend <= 1'b0;
            busy     <= 1'b1;
            state    <= PULSE;
          end else if (clr_req) begin
            r        <= 1'b1;
            clr_pend <= 1'b0;
            busy     <= 1'b1;
            state    <= PULSE;
          end
        end
        PULSE: begin
          hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
          state    <= GAP;
        end
        GAP: begin
          if (hold_cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SRCMD_CONFLICT_CNT_EN
  logic conflict_hit;
  assign conflict_hit = (state == IDLE) & set_req & clr_req;

  // Saturating count of requests dropped by arbitration
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_cnt <= '0;
    end else if (conflict_hit && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + CONF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// tb/tb_sr_cmd_conditioner.sv - scoreboard bench for sr_cmd_conditioner
module tb_sr_cmd_conditioner;

  localparam int CONF_W = 8;
  localparam int LAT    = 7;

  logic clk;
  logic reset;
  logic set_in;
  logic clr_in;
  logic s;
  logic r;
  logic busy;
`ifdef SRCMD_CONFLICT_CNT_EN
  logic [CONF_W-1:0] conflict_cnt;
`endif

  int cyc;
  int n_cmp;
  int n_bad;
  int exp_kind[$];
  int exp_cyc[$];

  sr_cmd_conditioner dut (
    .clk    (clk),
    .reset  (reset),
    .set_in (set_in),
    .clr_in (clr_in),
    .s      (s),
    .r      (r),
    .busy   (busy)
`ifdef SRCMD_CONFLICT_CNT_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic expect_pulse(input int kind, input int at);
    exp_kind.push_back(kind);
    exp_cyc.push_back(at);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every observed pulse is matched against the scoreboard
  always @(negedge clk) begin
    if (!reset && (s || r)) begin
      chk("s_r_exclusive", int'(s & r), 0);
      if (exp_kind.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got s=%0d r=%0d, expected none (cycle %0d)", s, r, cyc);
      end else begin
        chk("pulse_kind", r ? 1 : 0, exp_kind.pop_front());
        chk("pulse_cycle", cyc, exp_cyc.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    cyc    = 0;
    n_cmp  = 0;
    n_bad  = 0;
    reset  = 1'b1;
    set_in = 1'b0;
    clr_in = 1'b0;

    // Test 1: reset held with set_in high, then released
    @(negedge clk);
    set_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outputs", {s, r, busy}, 0);
    end
`ifdef SRCMD_CONFLICT_CNT_EN
    chk("reset_conflict_cnt", conflict_cnt, 0);
`endif
    reset = 1'b0;
    c = cyc;
    expect_pulse(0, c + LAT);
    idle(10);
    set_in = 1'b0;
    idle(20);
    chk("t1_drained", exp_kind.size(), 0);

    // Test 2: single set request, busy window
    c = cyc;
    set_in = 1'b1;
    expect_pulse(0, c + LAT);
    idle(LAT);
    chk("t2_busy0", busy, 1);
    idle(1);
    chk("t2_busy1", busy, 1);
    idle(1);
    chk("t2_busy2", busy, 1);
    idle(1);
    chk("t2_busy_end", busy, 0);
    idle(10);
    set_in = 1'b0;
    idle(20);
    chk("t2_drained", exp_kind.size(), 0);

    // Test 3: 3-cycle glitch shorter than the debounce window
    set_in = 1'b1;
    idle(3);
    set_in = 1'b0;
    idle(25);
    chk("t3_drained", exp_kind.size(), 0);
    chk("t3_idle", busy, 0);

    // Test 4: simultaneous requests, set wins
    c = cyc;
    set_in = 1'b1;
    clr_in = 1'b1;
    expect_pulse(0, c + LAT);
    idle(12);
`ifdef SRCMD_CONFLICT_CNT_EN
    chk("t4_conflict_cnt", conflict_cnt, 1);
`endif
    set_in = 1'b0;
    clr_in = 1'b0;
    idle(20);
    chk("t4_drained", exp_kind.size(), 0);

    // Test 5: clear one cycle after set, deferred through the gap
    c = cyc;
    set_in = 1'b1;
    expect_pulse(0, c + LAT);
    idle(1);
    clr_in = 1'b1;
    expect_pulse(1, c + LAT + 4);
    idle(15);
    set_in = 1'b0;
    clr_in = 1'b0;
    idle(20);
    chk("t5_drained", exp_kind.size(), 0);

    // Test 6: reset mid-debounce discards the request
    c = cyc;
    set_in = 1'b1;
    idle(4);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_reset_outputs", {s, r, busy}, 0);
`ifdef SRCMD_CONFLICT_CNT_EN
    chk("t6_conflict_cnt", conflict_cnt, 0);
`endif
    reset = 1'b0;
    c = cyc;
    expect_pulse(0, c + LAT);
    idle(15);
    set_in = 1'b0;
    idle(20);
    chk("t6_drained", exp_kind.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
